// File: rtl/icu_pkg.sv
// Shared definitions for the icu_ng control unit: opcodes, pulse bundle and
// instruction field helpers.
package icu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INST_W_MAX = 4 + 32;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
    OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
    OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
    OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
  } opcode_e;

  typedef struct packed {
    logic jmp;
    logic rtn;
    logic flag_o;
    logic flag_f;
  } pulse_t;

  function automatic int inst_w(input int addr_w);
    return 4 + addr_w;
  endfunction

  // Helpers take the instruction zero-extended to INST_W_MAX bits.
  function automatic opcode_e inst_opcode(input logic [INST_W_MAX-1:0] inst, input int addr_w);
    logic [INST_W_MAX-1:0] sh;
    sh = inst >> addr_w;
    return opcode_e'(sh[3:0]);
  endfunction

  function automatic logic [31:0] inst_operand(input logic [INST_W_MAX-1:0] inst, input int addr_w);
    logic [INST_W_MAX-1:0] mask;
    mask = ~({INST_W_MAX{1'b1}} << addr_w);
    return 32'(inst & mask);
  endfunction

endpackage

// File: rtl/icu_stack.sv
// Synchronous return-address LIFO; pushes to a full stack and pops of an
// empty stack are ignored.
module icu_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0] sp_q;
  logic [W-1:0]    mem_q [DEPTH];

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign dout  = empty ? '0 : mem_q[IDX_W'(sp_q - SP_W'(1))];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (RST) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; sp_q alone defines
  // which entries are meaningful, so the memory can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (!RST && push && !full) begin
      mem_q[IDX_W'(sp_q)] <= din;
    end
  end

endmodule

// File: rtl/icu_ng.sv
// WIDTH-bit industrial control unit with internal PC, return stack and
// operand-addressed I/O; one instruction per cycle when run & inst_valid.
module icu_ng
  import icu_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int IO_AW       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int INST_W     = inst_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              run,
  output logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic [IO_AW-1:0]  io_addr,
  input  logic [WIDTH-1:0]  io_rdata,
  output logic              io_we,
  output logic [WIDTH-1:0]  io_wdata,
  output logic [WIDTH-1:0]  RR,
  output logic              JMP,
  output logic              RTN,
  output logic              FLAG_O,
  output logic              FLAG_F,
  output logic              err_ovf,
  output logic              err_unf
);

  opcode_e           op;
  logic [ADDR_W-1:0] operand;
  logic [WIDTH-1:0]  d;
  logic              exec;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  rr_q, rr_d;
  logic              ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  pulse_t            pulse_q, pulse_d;

  logic              push, pop, full, empty;
  logic [ADDR_W-1:0] stk_dout;

  assign op      = inst_opcode(INST_W_MAX'(inst), ADDR_W);
  assign operand = ADDR_W'(inst_operand(INST_W_MAX'(inst), ADDR_W));
  assign io_addr = operand[IO_AW-1:0];
  assign d       = ien_q ? io_rdata : '0;
  assign exec    = run & inst_valid & ~RST;

  icu_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + ADDR_W'(1)),
    .dout  (stk_dout),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    pc_d     = pc_q;
    rr_d     = rr_q;
    ien_d    = ien_q;
    oen_d    = oen_q;
    skip_d   = skip_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    pulse_d  = '0;
    push     = 1'b0;
    pop      = 1'b0;
    io_we    = 1'b0;
    io_wdata = '0;
    if (exec) begin
      pc_d   = pc_q + ADDR_W'(1);
      skip_d = 1'b0;
      // A pending skip consumes this instruction with no other effect.
      if (!skip_q) begin
        case (op)
          OP_NOPO: pulse_d.flag_o = 1'b1;
          OP_LD:   rr_d = d;
          OP_LDC:  rr_d = ~d;
          OP_AND:  rr_d = rr_q & d;
          OP_ANDC: rr_d = rr_q & ~d;
          OP_OR:   rr_d = rr_q | d;
          OP_ORC:  rr_d = rr_q | ~d;
          OP_XNOR: rr_d = ~(rr_q ^ d);
          OP_STO: begin
            io_we    = oen_q;
            io_wdata = rr_q;
          end
          OP_STOC: begin
            io_we    = oen_q;
            io_wdata = ~rr_q;
          end
          OP_IEN:  ien_d = io_rdata[0];
          OP_OEN:  oen_d = io_rdata[0];
          OP_JMP: begin
            push        = ~full;
            ovf_d       = ovf_q | full;
            pc_d        = operand;
            pulse_d.jmp = 1'b1;
          end
          OP_RTN: begin
            pulse_d.rtn = 1'b1;
            if (empty) begin
              pc_d  = '0;
              unf_d = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = stk_dout;
            end
          end
          OP_SKZ:  skip_d = (rr_q == '0);
          OP_NOPF: pulse_d.flag_f = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pc_q    <= '0;
      rr_q    <= '0;
      ien_q   <= 1'b1;
      oen_q   <= 1'b1;
      skip_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rr_q    <= rr_d;
      ien_q   <= ien_d;
      oen_q   <= oen_d;
      skip_q  <= skip_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      pulse_q <= pulse_d;
    end
  end

  assign pc      = pc_q;
  assign RR      = rr_q;
  assign JMP     = pulse_q.jmp;
  assign RTN     = pulse_q.rtn;
  assign FLAG_O  = pulse_q.flag_o;
  assign FLAG_F  = pulse_q.flag_f;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule
